// File: rtl/mini_processor_if.sv
// mini_processor_if: run/pc control and observation bus of the mini_processor core.
`default_nettype none

interface mini_processor_if;
    logic        run;
    logic [2:0]  pc;
    logic [3:0]  state;
    logic [15:0] ALU_result;
    logic [2:0]  flags;

    modport master (
        output run,
        output pc,
        input  state,
        input  ALU_result,
        input  flags
    );

    modport slave (
        input  run,
        input  pc,
        output state,
        output ALU_result,
        output flags
    );
endinterface

`default_nettype wire

// File: rtl/mini_processor.sv
// +-----------------------------------------------------------------------+
// | mini_processor: multi-cycle 16-bit core, 8-entry ROM, 8x16 regfile,   |
// | ALU with {Z,N,C} flags.                       Revision: 1.0            |
// +-----------------------------------------------------------------------+
`default_nettype none

module mini_processor (
    input  wire logic        clk,
    input  wire logic        rst,
    mini_processor_if.slave  bus
);

    localparam logic [3:0] C_IDLE    = 4'b0001;
    localparam logic [3:0] C_FETCH   = 4'b0010;
    localparam logic [3:0] C_DECODE  = 4'b0100;
    localparam logic [3:0] C_EXECUTE = 4'b1000;

    localparam logic [3:0] C_OP_ADD = 4'd0;
    localparam logic [3:0] C_OP_SUB = 4'd1;
    localparam logic [3:0] C_OP_AND = 4'd2;
    localparam logic [3:0] C_OP_OR  = 4'd3;
    localparam logic [3:0] C_OP_XOR = 4'd4;
    localparam logic [3:0] C_OP_NOT = 4'd5;
    localparam logic [3:0] C_OP_SHL = 4'd6;
    localparam logic [3:0] C_OP_SHR = 4'd7;
    localparam logic [3:0] C_OP_LDI = 4'd8;
    localparam logic [3:0] C_OP_MOV = 4'd9;

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic        w_fetch_en;
    logic        w_decode_en;
    logic        w_exec_en;

    logic [15:0] r_ir;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_regs [8];
    logic [15:0] r_result;
    logic [2:0]  r_flags;

    logic [15:0] w_rom_data;
    logic [15:0] w_alu;
    logic        w_carry;
    logic        w_write;
    logic [16:0] w_sum;
    logic [16:0] w_diff;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = C_IDLE;
        case (r_state)
            C_IDLE:    w_next_state = bus.run ? C_FETCH : C_IDLE;
            C_FETCH:   w_next_state = C_DECODE;
            C_DECODE:  w_next_state = C_EXECUTE;
            C_EXECUTE: w_next_state = bus.run ? C_FETCH : C_IDLE;
            default:   w_next_state = C_IDLE;
        endcase
    end

    // Stage enables decoded from the state
    always_comb begin
        w_fetch_en  = 1'b0;
        w_decode_en = 1'b0;
        w_exec_en   = 1'b0;
        case (r_state)
            C_FETCH:   w_fetch_en  = 1'b1;
            C_DECODE:  w_decode_en = 1'b1;
            C_EXECUTE: w_exec_en   = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_rom_data = 16'h0000;
        case (bus.pc)
            3'd0: w_rom_data = 16'h8205;
            3'd1: w_rom_data = 16'h8403;
            3'd2: w_rom_data = 16'h0650;
            3'd3: w_rom_data = 16'h1888;
            3'd4: w_rom_data = 16'h2A50;
            3'd5: w_rom_data = 16'h4C48;
            3'd6: w_rom_data = 16'h6F00;
            3'd7: w_rom_data = 16'h01D0;
            default: w_rom_data = 16'h0000;
        endcase
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_alu   = 16'h0000;
        w_carry = 1'b0;
        w_write = 1'b1;
        case (r_ir[15:12])
            C_OP_ADD: begin w_alu = w_sum[15:0];  w_carry = w_sum[16]; end
            // Bit 16 of the 17-bit difference is set exactly when A < B unsigned.
            C_OP_SUB: begin w_alu = w_diff[15:0]; w_carry = w_diff[16]; end
            C_OP_AND: w_alu = r_a & r_b;
            C_OP_OR:  w_alu = r_a | r_b;
            C_OP_XOR: w_alu = r_a ^ r_b;
            C_OP_NOT: w_alu = ~r_a;
            C_OP_SHL: begin w_alu = {r_a[14:0], 1'b0}; w_carry = r_a[15]; end
            C_OP_SHR: begin w_alu = {1'b0, r_a[15:1]}; w_carry = r_a[0];  end
            C_OP_LDI: w_alu = {{7{r_ir[8]}}, r_ir[8:0]};
            C_OP_MOV: w_alu = r_a;
            default:  w_write = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir     <= 16'h0000;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_result <= 16'h0000;
            r_flags  <= 3'b000;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            if (w_fetch_en) begin
                r_ir <= w_rom_data;
            end
            if (w_decode_en) begin
                r_a <= r_regs[r_ir[8:6]];
                r_b <= r_regs[r_ir[5:3]];
            end
            if (w_exec_en && w_write) begin
                r_regs[r_ir[11:9]] <= w_alu;
                r_result           <= w_alu;
                r_flags            <= {(w_alu == 16'h0000), w_alu[15], w_carry};
            end
        end
    end

    assign bus.state      = r_state;
    assign bus.ALU_result = r_result;
    assign bus.flags      = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_mini_processor.sv
// Directed testbench for mini_processor: reset, program run, run drop, mid-op reset, pc stability.
`default_nettype none

module tb_mini_processor;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mini_processor_if bus ();

    mini_processor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [15:0] exp_res [8];
    logic [2:0]  exp_flg [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_res = '{16'h0005, 16'h0003, 16'h0008, 16'hFFFE,
                    16'h0001, 16'h0000, 16'hFFFC, 16'hFFFF};
        exp_flg = '{3'b000, 3'b000, 3'b000, 3'b011,
                    3'b000, 3'b100, 3'b011, 3'b010};

        // Reset held with run=1
        rst = 1'b1;
        bus.run = 1'b1;
        bus.pc  = 3'd0;
        step();
        step();
        chk("rst_state", {12'h0, bus.state}, 16'h0001);
        chk("rst_result", bus.ALU_result, 16'h0000);
        chk("rst_flags", {13'h0, bus.flags}, 16'h0000);

        rst = 1'b0;
        bus.run = 1'b0;
        step();
        chk("idle_hold1", {12'h0, bus.state}, 16'h0001);
        step();
        chk("idle_hold2", {12'h0, bus.state}, 16'h0001);

        // Program run; pc is scrambled after FETCH to show it is ignored
        bus.run = 1'b1;
        step();
        chk("st_fetch0", {12'h0, bus.state}, 16'h0002);
        for (int i = 0; i < 8; i++) begin
            bus.pc = 3'(i);
            step();
            chk($sformatf("st_decode%0d", i), {12'h0, bus.state}, 16'h0004);
            bus.pc = 3'(i + 3);
            step();
            chk($sformatf("st_exec%0d", i), {12'h0, bus.state}, 16'h0008);
            bus.pc = ~3'(i);
            step();
            chk($sformatf("res_pc%0d", i), bus.ALU_result, exp_res[i]);
            chk($sformatf("flg_pc%0d", i), {13'h0, bus.flags}, {13'h0, exp_flg[i]});
            chk($sformatf("st_next%0d", i), {12'h0, bus.state}, 16'h0002);
        end

        // Run dropped during DECODE of pc2
        bus.pc = 3'd2;
        step();
        bus.run = 1'b0;
        step();
        chk("drop_exec", {12'h0, bus.state}, 16'h0008);
        step();
        chk("drop_result", bus.ALU_result, 16'h0008);
        chk("drop_flags", {13'h0, bus.flags}, 16'h0000);
        chk("drop_idle", {12'h0, bus.state}, 16'h0001);
        step();
        chk("drop_idle_hold", {12'h0, bus.state}, 16'h0001);
        chk("drop_result_hold", bus.ALU_result, 16'h0008);
        bus.run = 1'b1;
        step();
        chk("resume_fetch", {12'h0, bus.state}, 16'h0002);

        // Reset asserted during EXECUTE of pc3
        bus.pc = 3'd3;
        step();
        step();
        chk("mid_exec", {12'h0, bus.state}, 16'h0008);
        rst = 1'b1;
        step();
        chk("mid_rst_state", {12'h0, bus.state}, 16'h0001);
        chk("mid_rst_result", bus.ALU_result, 16'h0000);
        chk("mid_rst_flags", {13'h0, bus.flags}, 16'h0000);
        rst = 1'b0;
        step();
        chk("rerun_fetch", {12'h0, bus.state}, 16'h0002);
        bus.pc = 3'd2;
        step();
        step();
        step();
        chk("rerun_result", bus.ALU_result, 16'h0000);
        chk("rerun_flags", {13'h0, bus.flags}, 16'h0004);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
